mem_axi_arbiter: RTL and testbench

- Shares one AXI4 master port to main memory between the instruction cache (read-only bursts) and the data cache (read and write-back bursts).
- Sits between the two cache miss interfaces and the memory/AXI slave.
- Independent read and write channel FSMs; 2-way round-robin on reads.
- Sequences AR/R and AW/W/B handshakes and returns per-beat data strobes to the owning cache.

---
 rtl/mem_axi_arbiter_pkg.sv | 33 +++
 rtl/mem_axi_write_ch.sv | 110 +++++++++++
 rtl/mem_axi_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_axi_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_axi_arbiter_pkg.sv
// Shared encodings for the icache/dcache AXI4 arbiter: FSM states, owner IDs,
// burst type and the two-way round-robin pick.
package mem_axi_arbiter_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_DATA = 2'd2,
        W_B    = 2'd3
    } wr_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam logic [1:0] BURST_INCR = 2'b01;

    // Under contention the requester that did not win last time goes next.
    function automatic owner_e rr_pick(input logic req_i, input logic req_d, input owner_e last);
        if (req_i && req_d) begin
            return (last == OWN_I) ? OWN_D : OWN_I;
        end
        return req_d ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_axi_write_ch.sv
// Dcache write-back channel: sequences AW, W beats and B for one burst at a time.
module mem_axi_write_ch
    import mem_axi_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    d_wvalid,
    output logic                    d_wready,
    input  logic [ADDR_WIDTH-1:0]   d_waddr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    input  logic [2:0]              d_wsize,
    input  logic [7:0]              d_wlen,
    output logic                    d_bvalid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic                    bvalid,
    output logic                    bready,
    output logic                    w_idle
);

    wr_state_e               state_q, state_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [7:0]              awlen_q, awlen_d;
    logic [2:0]              awsize_q, awsize_d;
    logic [7:0]              cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= W_IDLE;
            awaddr_q <= '0;
            awlen_q  <= '0;
            awsize_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            awaddr_q <= awaddr_d;
            awlen_q  <= awlen_d;
            awsize_q <= awsize_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        awaddr_d = awaddr_q;
        awlen_d  = awlen_q;
        awsize_d = awsize_q;
        cnt_d    = cnt_q;
        awvalid  = 1'b0;
        wvalid   = 1'b0;
        bready   = 1'b0;
        d_wready = 1'b0;
        d_bvalid = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (d_wvalid) begin
                    awaddr_d = d_waddr;
                    awlen_d  = d_wlen;
                    awsize_d = d_wsize;
                    cnt_d    = d_wlen;
                    state_d  = W_AW;
                end
            end
            W_AW: begin
                awvalid = 1'b1;
                if (awready) state_d = W_DATA;
            end
            W_DATA: begin
                wvalid = 1'b1;
                if (wready) begin
                    d_wready = 1'b1;
                    cnt_d    = cnt_q - 8'd1;
                    if (cnt_q == 8'd0) state_d = W_B;
                end
            end
            W_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    d_bvalid = 1'b1;
                    state_d  = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    // Beat data is not buffered: the dcache presents the current beat directly.
    assign wdata   = d_wdata;
    assign wstrb   = d_wstrb;
    assign wlast   = (state_q == W_DATA) && (cnt_q == 8'd0);
    assign awaddr  = awaddr_q;
    assign awlen   = awlen_q;
    assign awsize  = awsize_q;
    assign awburst = BURST_INCR;
    assign w_idle  = (state_q == W_IDLE);

endmodule

// File: rtl/mem_axi_arbiter.sv
// Shares one AXI4 master between icache refills and dcache refills/write-backs.
// Reads are round-robin arbitrated here; writes live in mem_axi_write_ch.
module mem_axi_arbiter
    import mem_axi_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_rvalid,
    output logic                    i_rready,
    input  logic [ADDR_WIDTH-1:0]   i_raddr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_rlast,
    input  logic [2:0]              i_rsize,
    input  logic [7:0]              i_rlen,
    input  logic                    d_rvalid,
    output logic                    d_rready,
    input  logic [ADDR_WIDTH-1:0]   d_raddr,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_rlast,
    input  logic [2:0]              d_rsize,
    input  logic [7:0]              d_rlen,
    input  logic                    d_wvalid,
    output logic                    d_wready,
    input  logic [ADDR_WIDTH-1:0]   d_waddr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    input  logic [2:0]              d_wsize,
    input  logic [7:0]              d_wlen,
    output logic                    d_bvalid,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    rd_state_e             rd_state_q, rd_state_d;
    owner_e                owner_q, owner_d;
    owner_e                rr_last_q, rr_last_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;
    logic [2:0]            arsize_q, arsize_d;
    logic                  w_idle;
    logic                  cand_i, cand_d, beat;
    logic                  unused_resp;

    mem_axi_write_ch #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_write_ch (
        .clk      (clk),
        .rst      (rst),
        .d_wvalid (d_wvalid),
        .d_wready (d_wready),
        .d_waddr  (d_waddr),
        .d_wdata  (d_wdata),
        .d_wstrb  (d_wstrb),
        .d_wsize  (d_wsize),
        .d_wlen   (d_wlen),
        .d_bvalid (d_bvalid),
        .awaddr   (awaddr),
        .awlen    (awlen),
        .awsize   (awsize),
        .awburst  (awburst),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wlast    (wlast),
        .wvalid   (wvalid),
        .wready   (wready),
        .bvalid   (bvalid),
        .bready   (bready),
        .w_idle   (w_idle)
    );

    // A dcache refill must not overtake its own pending write-back.
    assign cand_i = i_rvalid;
    assign cand_d = d_rvalid && w_idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            owner_q    <= OWN_I;
            rr_last_q  <= OWN_I;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arsize_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arsize_q   <= arsize_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        arsize_d   = arsize_q;
        case (rd_state_q)
            R_IDLE: begin
                if (cand_i || cand_d) begin
                    owner_d    = rr_pick(cand_i, cand_d, rr_last_q);
                    rr_last_d  = owner_d;
                    araddr_d   = (owner_d == OWN_D) ? d_raddr : i_raddr;
                    arlen_d    = (owner_d == OWN_D) ? d_rlen  : i_rlen;
                    arsize_d   = (owner_d == OWN_D) ? d_rsize : i_rsize;
                    rd_state_d = R_AR;
                end
            end
            R_AR: begin
                if (arready) rd_state_d = R_DATA;
            end
            R_DATA: begin
                if (rvalid && rlast) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    assign arvalid  = (rd_state_q == R_AR);
    assign rready   = (rd_state_q == R_DATA);
    assign beat     = rready && rvalid;
    assign i_rready = beat && (owner_q == OWN_I);
    assign d_rready = beat && (owner_q == OWN_D);
    assign i_rlast  = i_rready && rlast;
    assign d_rlast  = d_rready && rlast;
    assign i_rdata  = rdata;
    assign d_rdata  = rdata;
    assign araddr   = araddr_q;
    assign arlen    = arlen_q;
    assign arsize   = arsize_q;
    assign arburst  = BURST_INCR;

    // Error responses are not reported back to the caches.
    assign unused_resp = ^{rresp, bresp};

endmodule

// File: tb/tb_mem_axi_arbiter.sv
// Directed bench for mem_axi_arbiter: read beats go through a scoreboard queue,
// write and handshake behaviour is checked inline.
module tb_mem_axi_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_rvalid, i_rready, i_rlast, d_rvalid, d_rready, d_rlast;
    logic [AW-1:0] i_raddr, d_raddr, d_waddr, araddr, awaddr;
    logic [DW-1:0] i_rdata, d_rdata, d_wdata, rdata, wdata;
    logic [2:0]    i_rsize, d_rsize, d_wsize, arsize, awsize;
    logic [7:0]    i_rlen, d_rlen, d_wlen, arlen, awlen;
    logic          d_wvalid, d_wready, d_bvalid;
    logic [3:0]    d_wstrb, wstrb;
    logic [1:0]    arburst, awburst, rresp, bresp;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    typedef struct packed {
        logic        own;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    always #5 clk = ~clk;

    mem_axi_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .i_rvalid(i_rvalid), .i_rready(i_rready), .i_raddr(i_raddr), .i_rdata(i_rdata),
        .i_rlast(i_rlast), .i_rsize(i_rsize), .i_rlen(i_rlen),
        .d_rvalid(d_rvalid), .d_rready(d_rready), .d_raddr(d_raddr), .d_rdata(d_rdata),
        .d_rlast(d_rlast), .d_rsize(d_rsize), .d_rlen(d_rlen),
        .d_wvalid(d_wvalid), .d_wready(d_wready), .d_waddr(d_waddr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_wsize(d_wsize), .d_wlen(d_wlen), .d_bvalid(d_bvalid),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    wire [10:0] ctrl_out = {arvalid, rready, i_rready, d_rready, i_rlast, d_rlast,
                            awvalid, wvalid, bready, d_wready, d_bvalid};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every read beat strobed to a cache must match the oldest expected beat.
    always @(negedge clk) begin
        if (i_rready || d_rready) begin
            if (sb.size() == 0) begin
                chk("beat_unexpected", 64'({i_rready, d_rready}), 64'd0);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("beat_owner", 64'({i_rready, d_rready}), 64'({e.own == 1'b0, e.own == 1'b1}));
                chk("beat_data", 64'(i_rready ? i_rdata : d_rdata), 64'(e.data));
                chk("beat_last", 64'({i_rlast, d_rlast}),
                    64'({e.last && e.own == 1'b0, e.last && e.own == 1'b1}));
            end
        end
    end

    task automatic wait_ar(output int lat);
        lat = 0;
        while (!arvalid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic rd_burst(input logic own, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input int ar_delay, input logic [31:0] base,
                            input int exp_lat);
        int lat;
        wait_ar(lat);
        chk("ar_seen", 64'(arvalid), 64'd1);
        if (exp_lat >= 0) chk("ar_latency", 64'(lat), 64'(exp_lat));
        chk("araddr", 64'(araddr), 64'(addr));
        chk("arlen", 64'(arlen), 64'(len));
        chk("arsize", 64'(arsize), 64'(size));
        chk("arburst", 64'(arburst), 64'd1);
        for (int k = 0; k < ar_delay; k++) begin
            tick();
            chk("ar_hold_valid", 64'(arvalid), 64'd1);
            chk("ar_hold_addr", 64'(araddr), 64'(addr));
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("r_phase", 64'({arvalid, rready}), 64'b01);
        for (int b = 0; b <= int'(len); b++) begin
            rvalid = 1'b1;
            rdata  = base + 32'(b);
            rlast  = (b == int'(len));
            sb.push_back('{own: own, data: base + 32'(b), last: (b == int'(len))});
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        chk("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic wr_start(input logic [31:0] addr, input logic [7:0] len);
        d_wvalid = 1'b1;
        d_waddr  = addr;
        d_wlen   = len;
        d_wsize  = 3'd2;
        tick();
        chk("awvalid", 64'({awvalid, wvalid}), 64'b10);
        chk("awaddr", 64'(awaddr), 64'(addr));
        chk("awlen_size_burst", 64'({awlen, awsize, awburst}), 64'({len, 3'd2, 2'b01}));
        awready = 1'b1;
        tick();
        awready = 1'b0;
    endtask

    task automatic wr_beats(input logic [7:0] len, input logic [31:0] base, input logic toggle);
        int b = 0;
        int c = 0;
        int pulses = 0;
        while (b <= int'(len) && c < 40) begin
            wready  = toggle ? (c % 2 == 0) : 1'b1;
            d_wdata = base + 32'(b);
            d_wstrb = 4'(b) ^ 4'hF;
            #1;
            chk("wvalid", 64'(wvalid), 64'd1);
            chk("wlast", 64'(wlast), 64'(b == int'(len)));
            chk("d_wready", 64'(d_wready), 64'(wready));
            chk("wdata_wstrb", 64'({wdata, wstrb}), 64'({base + 32'(b), 4'(b) ^ 4'hF}));
            chk("ar_blocked", 64'(arvalid), 64'd0);
            if (d_wready) pulses++;
            tick();
            if (wready) b++;
            c++;
        end
        wready = 1'b0;
        chk("d_wready_pulses", 64'(pulses), 64'(int'(len) + 1));
    endtask

    task automatic wr_resp();
        chk("b_wait", 64'({bready, d_bvalid, wvalid, arvalid}), 64'b1000);
        tick();
        bvalid = 1'b1;
        #1;
        chk("d_bvalid_pulse", 64'({bready, d_bvalid}), 64'b11);
        tick();
        bvalid   = 1'b0;
        d_wvalid = 1'b0;
        chk("b_done", 64'({bready, d_bvalid, awvalid}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        {i_rvalid, d_rvalid, d_wvalid, arready, rvalid, rlast, awready, wready, bvalid} = '0;
        i_raddr = '0; d_raddr = '0; d_waddr = '0; d_wdata = '0; d_wstrb = '0; rdata = '0;
        i_rsize = 3'd2; d_rsize = 3'd2; d_wsize = 3'd2;
        i_rlen = '0; d_rlen = '0; d_wlen = '0; rresp = '0; bresp = '0;
        repeat (2) tick();
        chk("reset_ctrl", 64'(ctrl_out), 64'd0);
        chk("reset_ar", 64'({araddr, arlen, arsize}), 64'd0);
        chk("reset_aw", 64'({awaddr, awlen, awsize}), 64'd0);
        rst = 1'b0;

        // Icache-only refill, zero-latency slave.
        i_rvalid = 1'b1; i_raddr = 32'h1000; i_rlen = 8'd3; i_rsize = 3'd2;
        rd_burst(1'b0, 32'h1000, 8'd3, 3'd2, 0, 32'hA000_0000, 1);
        i_rvalid = 1'b0;
        tick();

        // Contention after reset: dcache first, then icache, then alternate.
        i_rvalid = 1'b1; i_raddr = 32'h5000; i_rlen = 8'd1;
        d_rvalid = 1'b1; d_raddr = 32'h6000; d_rlen = 8'd1;
        rd_burst(1'b1, 32'h6000, 8'd1, 3'd2, 0, 32'hB000_0000, 1);
        d_raddr = 32'h7000; d_rlen = 8'd0;
        rd_burst(1'b0, 32'h5000, 8'd1, 3'd2, 0, 32'hB100_0000, 1);
        i_rvalid = 1'b0;
        rd_burst(1'b1, 32'h7000, 8'd0, 3'd2, 0, 32'hB200_0000, 1);
        i_rvalid = 1'b1; i_raddr = 32'h5400; i_rlen = 8'd0;
        d_raddr = 32'h7400;
        rd_burst(1'b0, 32'h5400, 8'd0, 3'd2, 0, 32'hB300_0000, 1);
        i_rvalid = 1'b0;
        rd_burst(1'b1, 32'h7400, 8'd0, 3'd2, 0, 32'hB400_0000, 1);
        d_rvalid = 1'b0;
        tick();

        // Dcache write-back with wready toggling.
        wr_start(32'h8000, 8'd3);
        wr_beats(8'd3, 32'hC000_0000, 1'b1);
        wr_resp();

        // Dcache refill held behind a write-back; icache refill overlaps it.
        wr_start(32'h2000, 8'd1);
        i_rvalid = 1'b1; i_raddr = 32'h3000; i_rlen = 8'd2;
        d_rvalid = 1'b1; d_raddr = 32'h4000; d_rlen = 8'd1;
        rd_burst(1'b0, 32'h3000, 8'd2, 3'd2, 0, 32'hD000_0000, 1);
        i_rvalid = 1'b0;
        wr_beats(8'd1, 32'hD100_0000, 1'b0);
        wr_resp();
        chk("ar_after_write", 64'(arvalid), 64'd0);
        rd_burst(1'b1, 32'h4000, 8'd1, 3'd2, 0, 32'hD200_0000, 1);
        d_rvalid = 1'b0;
        tick();

        // Single-beat write.
        wr_start(32'h8800, 8'd0);
        wr_beats(8'd0, 32'hE000_0000, 1'b0);
        wr_resp();

        // Slow arready: AR held stable for 5 cycles.
        i_rvalid = 1'b1; i_raddr = 32'h1100; i_rlen = 8'd1;
        rd_burst(1'b0, 32'h1100, 8'd1, 3'd2, 5, 32'hE100_0000, 1);
        i_rvalid = 1'b0;
        tick();

        // Reset during beat 2 of a dcache refill.
        d_rvalid = 1'b1; d_raddr = 32'h9000; d_rlen = 8'd3;
        begin
            int lat;
            wait_ar(lat);
        end
        chk("rst_ar_addr", 64'({arvalid, araddr}), 64'({1'b1, 32'h9000}));
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hF000_0000; rlast = 1'b0;
        sb.push_back('{own: 1'b1, data: 32'hF000_0000, last: 1'b0});
        tick();
        rdata = 32'hF000_0001;
        sb.push_back('{own: 1'b1, data: 32'hF000_0001, last: 1'b0});
        rst = 1'b1;
        tick();
        rst = 1'b0; rvalid = 1'b0; d_rvalid = 1'b0;
        chk("mid_rst_ctrl", 64'(ctrl_out), 64'd0);
        chk("mid_rst_ar", 64'({araddr, arlen, arsize}), 64'd0);
        chk("mid_rst_sb", 64'(sb.size()), 64'd0);
        tick();
        chk("mid_rst_idle", 64'(ctrl_out), 64'd0);

        // Round-robin pointer is back to icache: contention grants dcache.
        i_rvalid = 1'b1; i_raddr = 32'hB000; i_rlen = 8'd0;
        d_rvalid = 1'b1; d_raddr = 32'hC000; d_rlen = 8'd1;
        rd_burst(1'b1, 32'hC000, 8'd1, 3'd2, 0, 32'hF100_0000, 1);
        d_rvalid = 1'b0;
        rd_burst(1'b0, 32'hB000, 8'd0, 3'd2, 0, 32'hF200_0000, 1);
        i_rvalid = 1'b0;
        repeat (2) tick();
        chk("final_idle", 64'(ctrl_out), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
